// File: rtl/cubic_approx_pkg.sv
// Shared constants and fixed-point types for the cubic transfer stage.
package cubic_approx_pkg;

    localparam int unsigned IN_W      = 10;
    localparam int unsigned OUT_W     = 10;
    localparam int unsigned IN_FRAC   = 7;
    localparam int unsigned OUT_FRAC  = 6;
    localparam int unsigned K_Q10     = 870;
    localparam int unsigned K_FRAC    = 10;
    localparam int unsigned K_W       = 11;
    localparam int unsigned ONE_Q6    = 64;
    localparam int          OUT_MAX   = 511;
    localparam int          OUT_MIN   = -512;

    // Full-precision intermediate widths: x^2, x^3 and x^3*K
    localparam int unsigned X2_W      = 2 * IN_W;
    localparam int unsigned X3_W      = 3 * IN_W;
    localparam int unsigned P_W       = X3_W + K_W;
    localparam int unsigned RND_SHIFT = 3 * IN_FRAC + K_FRAC - OUT_FRAC;

    typedef logic signed [IN_W-1:0]  q2_7_t;
    typedef logic signed [OUT_W-1:0] q3_6_t;

endpackage

// File: rtl/cubic_approx_if.sv
// Streaming sample bus: one qualified operand in, one qualified result out.
interface cubic_approx_if;
    import cubic_approx_pkg::*;

    logic  in_valid;
    q2_7_t in;
    logic  out_valid;
    q3_6_t out;
    logic  sat;

    modport master (output in_valid, in, input out_valid, out, sat);
    modport slave  (input in_valid, in, output out_valid, out, sat);
endinterface

// File: rtl/cubic_approx_sat_round.sv
// Stage-3 tail: round Q.31 product to Q.6, add 1.0, clamp to the output range.
module cubic_approx_sat_round
    import cubic_approx_pkg::*;
(
    input  logic signed [P_W-1:0] p,
    output q3_6_t                 res_c,
    output logic                  sat_c
);
    localparam logic signed [P_W-1:0] RND     = P_W'(1 << (RND_SHIFT - 1));
    localparam logic signed [P_W-1:0] ONE     = P_W'(ONE_Q6);
    localparam logic signed [P_W-1:0] MAX_EXT = P_W'(OUT_MAX);
    localparam logic signed [P_W-1:0] MIN_EXT = P_W'(OUT_MIN);

    logic signed [P_W-1:0] s;

    // Round half up via bias + arithmetic shift, offset by 1.0, then clamp
    always_comb begin
        s     = ((p + RND) >>> RND_SHIFT) + ONE;
        res_c = OUT_W'(s);
        sat_c = 1'b0;
        if (s > MAX_EXT) begin
            res_c = OUT_W'(OUT_MAX);
            sat_c = 1'b1;
        end else if (s < MIN_EXT) begin
            res_c = OUT_W'(OUT_MIN);
            sat_c = 1'b1;
        end
    end

endmodule

// File: rtl/cubic_approx.sv
// Three-stage pipelined evaluator of f(x) = 0.85*x^3 + 1.0 with saturation.
module cubic_approx
    import cubic_approx_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    cubic_approx_if.slave bus
);
    localparam logic signed [P_W-1:0] K_EXT = P_W'(K_Q10);

    logic                   s1_valid;
    logic signed [IN_W-1:0] s1_x;
    logic signed [X2_W-1:0] s1_x2;
    logic                   s2_valid;
    logic signed [X3_W-1:0] s2_x3;

    logic signed [X2_W-1:0] x_ext2;
    logic signed [X3_W-1:0] x_ext3;
    logic signed [X3_W-1:0] x2_ext3;
    logic signed [P_W-1:0]  p_c;
    q3_6_t                  res_c;
    logic                   sat_c;

    // Sign-extend operands to full product width so no bits are lost
    always_comb begin
        x_ext2  = X2_W'(bus.in);
        x_ext3  = X3_W'(s1_x);
        x2_ext3 = X3_W'(s1_x2);
        p_c     = P_W'(s2_x3) * K_EXT;
    end

    // Stage 1: capture x and x^2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_x2    <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_x     <= bus.in;
            s1_x2    <= x_ext2 * x_ext2;
        end
    end

    // Stage 2: x^3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_x3    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_x3    <= x2_ext3 * x_ext3;
        end
    end

    cubic_approx_sat_round u_sat_round (
        .p     (p_c),
        .res_c (res_c),
        .sat_c (sat_c)
    );

    // Stage 3: result register; out/sat hold through bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.sat       <= 1'b0;
        end else begin
            bus.out_valid <= s2_valid;
            if (s2_valid) begin
                bus.out <= res_c;
                bus.sat <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_cubic_approx.sv
// Self-checking bench for cubic_approx against a real-arithmetic reference.
module tb_cubic_approx;
    import cubic_approx_pkg::*;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    int   exp_last_out;
    bit   exp_last_sat;

    bit   vin[256];
    int   xin[256];
    bit   obs_v[256];
    int   obs_out[256];
    bit   obs_sat[256];

    cubic_approx_if bus ();

    cubic_approx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic real abs_real(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // f(x) in output LSBs, rounded half up from the Q0.10 coefficient product, then clamped
    function automatic void model(input int x, output int o, output bit s);
        real xr, r;
        xr = real'(x);
        r  = $floor(xr * xr * xr * 870.0 / 33554432.0 + 0.5) + 64.0;
        s  = 1'b0;
        if (r > 511.0) begin
            r = 511.0;
            s = 1'b1;
        end else if (r < -512.0) begin
            r = -512.0;
            s = 1'b1;
        end
        o = int'(r);
    endfunction

    function automatic real f_real(input int x);
        real xr;
        xr = real'(x) / 128.0;
        return 0.85 * xr * xr * xr + 1.0;
    endfunction

    // Drives vin/xin back-to-back and records the output seen 3 cycles later
    task automatic run_stream(input int n);
        for (int c = 0; c < n + 2; c++) begin
            bus.in_valid = (c < n) ? vin[c] : 1'b0;
            bus.in       = (c < n) ? IN_W'(xin[c]) : '0;
            step();
            if (c >= 2) begin
                obs_v[c-2]   = bus.out_valid;
                obs_out[c-2] = int'(bus.out);
                obs_sat[c-2] = bus.sat;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in = '0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0 || bus.sat !== 1'b0)
            $display("FAIL reset_initial: valid=%b out=%0d sat=%b expected 0/0/0", bus.out_valid, bus.out, bus.sat);
        else passed++;
        repeat (3) step();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in = IN_W'(128);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        total++;
        if (bus.out_valid !== 1'b1 || int'(bus.out) != 118)
            $display("FAIL reset_pre: valid=%b out=%0d expected 1/118", bus.out_valid, bus.out);
        else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0 || bus.sat !== 1'b0)
            $display("FAIL reset_async: valid=%b out=%0d sat=%b expected 0/0/0", bus.out_valid, bus.out, bus.sat);
        else passed++;
        step();
        step();
        total++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0 || bus.sat !== 1'b0)
            $display("FAIL reset_held: valid=%b out=%0d sat=%b expected 0/0/0", bus.out_valid, bus.out, bus.sat);
        else passed++;
        rst = 1'b0;
        step();
        exp_last_out = 0;
        exp_last_sat = 1'b0;
    endtask

    // Fixed operating points with explicit latency checks
    task automatic test_points(input string name, input int n, input int xs[8],
                               input int es[8], input bit ss[8]);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in = IN_W'(xs[i]);
            step();
            bus.in_valid = 1'b0;
            step();
            total++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL %s_early[%0d]: valid=%b expected 0", name, xs[i], bus.out_valid);
            else passed++;
            step();
            total++;
            if (bus.out_valid !== 1'b1 || int'(bus.out) != es[i] || bus.sat !== ss[i])
                $display("FAIL %s[%0d]: valid=%b out=%0d sat=%b expected 1/%0d/%b",
                         name, xs[i], bus.out_valid, bus.out, bus.sat, es[i], ss[i]);
            else passed++;
            step();
            total++;
            if (bus.out_valid !== 1'b0 || int'(bus.out) != es[i])
                $display("FAIL %s_hold[%0d]: valid=%b out=%0d expected 0/%0d",
                         name, xs[i], bus.out_valid, bus.out, es[i]);
            else passed++;
            exp_last_out = es[i];
            exp_last_sat = ss[i];
        end
    endtask

    task automatic test_core();
        int xs[8] = '{0, 128, -128, 256, -256, 0, 0, 0};
        int es[8] = '{64, 118, 10, 499, -371, 0, 0, 0};
        bit ss[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        test_points("core", 5, xs, es, ss);
    endtask

    task automatic test_saturation();
        int xs[8] = '{511, -512, 255, 0, 0, 0, 0, 0};
        int es[8] = '{511, -512, 494, 0, 0, 0, 0, 0};
        bit ss[8] = '{1, 1, 0, 0, 0, 0, 0, 0};
        test_points("sat", 3, xs, es, ss);
    endtask

    task automatic test_sweep();
        int  e;
        bit  s;
        real err_sum;
        int  err_n;
        real mean;
        err_sum = 0.0;
        err_n = 0;
        for (int i = 0; i < 128; i++) begin
            vin[i] = 1'b1;
            xin[i] = -512 + 8 * i;
        end
        run_stream(128);
        for (int j = 0; j < 128; j++) begin
            model(xin[j], e, s);
            total++;
            if (obs_v[j] !== 1'b1 || obs_out[j] != e || obs_sat[j] !== s)
                $display("FAIL sweep[%0d]: valid=%b out=%0d sat=%b expected 1/%0d/%b",
                         xin[j], obs_v[j], obs_out[j], obs_sat[j], e, s);
            else passed++;
            if (!s) begin
                real ideal;
                ideal = 64.0 * f_real(xin[j]);
                total++;
                if (abs_real(real'(obs_out[j]) - ideal) > 1.0)
                    $display("FAIL sweep_acc[%0d]: out=%0d expected within 1 of %f", xin[j], obs_out[j], ideal);
                else passed++;
            end
            if (xin[j] > -256 && xin[j] < 256) begin
                err_sum += abs_real(real'(obs_out[j]) / 64.0 - f_real(xin[j]));
                err_n++;
            end
        end
        mean = err_sum / real'(err_n);
        total++;
        if (mean >= 0.025)
            $display("FAIL sweep_mean_err: mean=%f expected < 0.025", mean);
        else passed++;
        model(xin[127], exp_last_out, exp_last_sat);
    endtask

    // Shared checker body for streams with bubbles, kept inline per test
    task automatic test_bubbles();
        int e;
        bit s;
        for (int i = 0; i < 40; i++) begin
            vin[i] = (i % 2 == 0);
            xin[i] = int'($urandom_range(0, 1023)) - 512;
        end
        run_stream(40);
        for (int j = 0; j < 40; j++) begin
            total++;
            if (obs_v[j] !== vin[j])
                $display("FAIL bubble_valid[%0d]: valid=%b expected %b", j, obs_v[j], vin[j]);
            else passed++;
            if (vin[j]) begin
                model(xin[j], e, s);
                exp_last_out = e;
                exp_last_sat = s;
            end
            total++;
            if (obs_out[j] != exp_last_out || obs_sat[j] !== exp_last_sat)
                $display("FAIL bubble_data[%0d]: out=%0d sat=%b expected %0d/%b",
                         j, obs_out[j], obs_sat[j], exp_last_out, exp_last_sat);
            else passed++;
        end
    endtask

    task automatic test_random();
        int e;
        bit s;
        for (int i = 0; i < 150; i++) begin
            vin[i] = ($urandom_range(0, 3) != 0);
            xin[i] = int'($urandom_range(0, 1023)) - 512;
        end
        run_stream(150);
        for (int j = 0; j < 150; j++) begin
            if (vin[j]) begin
                model(xin[j], e, s);
                exp_last_out = e;
                exp_last_sat = s;
            end
            total++;
            if (obs_v[j] !== vin[j] || obs_out[j] != exp_last_out || obs_sat[j] !== exp_last_sat)
                $display("FAIL random[%0d] x=%0d: valid=%b out=%0d sat=%b expected %b/%0d/%b",
                         j, xin[j], obs_v[j], obs_out[j], obs_sat[j], vin[j], exp_last_out, exp_last_sat);
            else passed++;
        end
    endtask

    task automatic test_reset_midstream();
        bus.in_valid = 1'b1;
        bus.in = IN_W'(256);
        step();
        bus.in = IN_W'(-256);
        step();
        bus.in_valid = 1'b0;
        bus.in = '0;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0 || bus.sat !== 1'b0)
            $display("FAIL midrst_async: valid=%b out=%0d sat=%b expected 0/0/0", bus.out_valid, bus.out, bus.sat);
        else passed++;
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (bus.out_valid !== 1'b0 || bus.out !== '0)
                $display("FAIL midrst_flush[%0d]: valid=%b out=%0d expected 0/0", c, bus.out_valid, bus.out);
            else passed++;
        end
        bus.in_valid = 1'b1;
        bus.in = IN_W'(-128);
        step();
        bus.in_valid = 1'b0;
        step();
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL midrst_early: valid=%b expected 0", bus.out_valid);
        else passed++;
        step();
        total++;
        if (bus.out_valid !== 1'b1 || int'(bus.out) != 10 || bus.sat !== 1'b0)
            $display("FAIL midrst_first: valid=%b out=%0d sat=%b expected 1/10/0", bus.out_valid, bus.out, bus.sat);
        else passed++;
        exp_last_out = 10;
        exp_last_sat = 1'b0;
    endtask

    initial begin
        passed = 0;
        total = 0;
        exp_last_out = 0;
        exp_last_sat = 1'b0;
        test_reset();
        test_core();
        test_saturation();
        test_sweep();
        test_bubbles();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
